// File: rtl/vivaldi_poly_osc.sv
// N-voice time-multiplexed oscillator bank with per-voice gain, saturating mixer and valid/ready output.
// Optional noise source on wave_sel 4 when VIVALDI_NOISE_EN is defined (16-bit Galois LFSR).
module vivaldi_poly_osc #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16,
  parameter int PHASE_W    = 24,
  parameter int LUT_AW     = 8,
  localparam int VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sample_tick_i,
  input  logic                cfg_we_i,
  input  logic [VW-1:0]       cfg_voice_i,
  input  logic [1:0]          cfg_addr_i,
  input  logic [PHASE_W-1:0]  cfg_wdata_i,
  output logic [SAMPLE_W-1:0] out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o,
  output logic                overrun_o
);

  localparam int MIX_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int PROD_W = SAMPLE_W + 9;
  localparam int LUT_DW = SAMPLE_W - 1;
  localparam int LUT_N  = 2 ** LUT_AW;
  localparam logic signed [SAMPLE_W-1:0] S_MAX     = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] S_MIN     = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [SAMPLE_W-1:0] S_NEG_MAX = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};
  localparam logic signed [MIX_W-1:0]    MIX_MAX   = MIX_W'(S_MAX);
  localparam logic signed [MIX_W-1:0]    MIX_MIN   = MIX_W'(S_MIN);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, OUT = 2'd2} state_t;

  state_t                      state_r, state_nxt_s;
  logic [VW-1:0]               voice_r;
  logic [PHASE_W-1:0]          phase_r [NUM_VOICES];
  logic [PHASE_W-1:0]          inc_r   [NUM_VOICES];
  logic [2:0]                  sel_r   [NUM_VOICES];
  logic [7:0]                  gain_r  [NUM_VOICES];
  logic signed [MIX_W-1:0]     mix_r;
  logic signed [SAMPLE_W-1:0]  out_data_r;
  logic                        out_valid_r, overrun_r;

  logic                        frame_start_s, accum_en_s, out_load_s, out_done_s, overrun_s;
  logic                        last_voice_s, cfg_hit_s;
  logic [SAMPLE_W:0]           ph_top_s;
  logic [2:0]                  cur_sel_s;
  logic [7:0]                  cur_gain_s, gain_eff_s;
  logic [1:0]                  quad_s;
  logic [LUT_AW-1:0]           lut_addr_s;
  logic [LUT_DW-1:0]           lut_s [LUT_N];
  logic signed [SAMPLE_W-1:0]  mag_s, sine_s, tri_s, wave_s;
  logic [SAMPLE_W-1:0]         tri_u_s;
  logic signed [PROD_W-1:0]    prod_s;
  logic signed [MIX_W-1:0]     voice_ext_s, mix_sum_s;
  logic signed [SAMPLE_W-1:0]  sat_s;

  // Quarter-wave sine table, sampled at bin centres so the mirrored quadrants stay symmetric
  for (genvar i = 0; i < LUT_N; i++) begin : g_lut
    localparam int LV = $rtoi(real'(S_MAX) * $sin(3.141592653589793 * (real'(i) + 0.5)
                              / (2.0 * real'(LUT_N))) + 0.5);
    assign lut_s[i] = LUT_DW'(LV);
  end

  assign last_voice_s = (voice_r == VW'(NUM_VOICES - 1));
  assign cfg_hit_s    = cfg_we_i && (int'(cfg_voice_i) < NUM_VOICES);
  assign ph_top_s     = phase_r[voice_r][PHASE_W-1 -: SAMPLE_W+1];
  assign cur_sel_s    = sel_r[voice_r];
  assign cur_gain_s   = gain_r[voice_r];

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= IDLE;
    else         state_r <= state_nxt_s;
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (sample_tick_i) state_nxt_s = ACCUM; else state_nxt_s = IDLE;
      ACCUM:   if (last_voice_s)  state_nxt_s = OUT;   else state_nxt_s = ACCUM;
      OUT:     if (out_ready_i)   state_nxt_s = IDLE;  else state_nxt_s = OUT;
      default: state_nxt_s = IDLE;
    endcase
  end

  // datapath strobes decoded from the current state
  always_comb begin
    frame_start_s = 1'b0;
    accum_en_s    = 1'b0;
    out_load_s    = 1'b0;
    out_done_s    = 1'b0;
    overrun_s     = sample_tick_i && (state_r != IDLE);
    case (state_r)
      IDLE:    frame_start_s = sample_tick_i;
      ACCUM:   begin accum_en_s = 1'b1; out_load_s = last_voice_s; end
      OUT:     out_done_s = out_ready_i;
      default: frame_start_s = 1'b0;
    endcase
  end

`ifdef VIVALDI_NOISE_EN
  logic [15:0] lfsr_r;
  // noise source steps once per voice evaluation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         lfsr_r <= 16'hACE1;
    else if (accum_en_s) lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hD008 : 16'h0000);
    else                 lfsr_r <= lfsr_r;
  end
`endif

  // waveform generation for the voice currently being evaluated
  always_comb begin
    quad_s     = ph_top_s[SAMPLE_W -: 2];
    lut_addr_s = quad_s[0] ? ~ph_top_s[SAMPLE_W-2 -: LUT_AW] : ph_top_s[SAMPLE_W-2 -: LUT_AW];
    mag_s      = {1'b0, lut_s[lut_addr_s]};
    sine_s     = quad_s[1] ? -mag_s : mag_s;
    tri_u_s    = ph_top_s[SAMPLE_W] ? ~ph_top_s[SAMPLE_W-1:0] : ph_top_s[SAMPLE_W-1:0];
    tri_s      = (tri_u_s == {SAMPLE_W{1'b1}}) ? S_MAX : tri_u_s - S_MAX;
    case (cur_sel_s)
      3'd0:    wave_s = sine_s;
      3'd1:    wave_s = ph_top_s[SAMPLE_W] ? S_NEG_MAX : S_MAX;
      3'd2:    wave_s = tri_s;
      3'd3:    wave_s = {~ph_top_s[SAMPLE_W], ph_top_s[SAMPLE_W-1 -: SAMPLE_W-1]};
`ifdef VIVALDI_NOISE_EN
      3'd4:    wave_s = SAMPLE_W'(signed'(lfsr_r));
`endif
      default: wave_s = '0;
    endcase
  end

  // gain scaling and saturating mix
  always_comb begin
    gain_eff_s  = (cur_gain_s > 8'd128) ? 8'd128 : cur_gain_s;
    prod_s      = PROD_W'(wave_s) * PROD_W'($signed({1'b0, gain_eff_s}));
    voice_ext_s = MIX_W'(prod_s >>> 3'd7);
    mix_sum_s   = mix_r + voice_ext_s;
    if (mix_sum_s > MIX_MAX)      sat_s = S_MAX;
    else if (mix_sum_s < MIX_MIN) sat_s = S_MIN;
    else                          sat_s = mix_sum_s[SAMPLE_W-1:0];
  end

  // per-voice config and phase; a phase_clear lands after the increment so it wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_r[i] <= '0;
        inc_r[i]   <= '0;
        sel_r[i]   <= 3'd0;
        gain_r[i]  <= 8'd0;
      end
    end else begin
      if (accum_en_s) phase_r[voice_r] <= phase_r[voice_r] + inc_r[voice_r];
      if (cfg_hit_s) begin
        case (cfg_addr_i)
          2'd0:    inc_r[cfg_voice_i]   <= cfg_wdata_i;
          2'd1:    sel_r[cfg_voice_i]   <= cfg_wdata_i[2:0];
          2'd2:    gain_r[cfg_voice_i]  <= cfg_wdata_i[7:0];
          default: phase_r[cfg_voice_i] <= '0;
        endcase
      end
    end
  end

  // frame accumulation and output register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      voice_r     <= '0;
      mix_r       <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      overrun_r <= overrun_s;
      if (frame_start_s) begin
        voice_r <= '0;
        mix_r   <= '0;
      end else if (accum_en_s) begin
        voice_r <= voice_r + VW'(1'b1);
        mix_r   <= mix_sum_s;
      end
      if (out_load_s) begin
        out_data_r  <= sat_s;
        out_valid_r <= 1'b1;
      end else if (out_done_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out_data_o  = out_data_r;
  assign out_valid_o = out_valid_r;
  assign busy_o      = (state_r != IDLE);
  assign overrun_o   = overrun_r;

endmodule

// File: tb/tb_vivaldi_poly_osc.sv
// Randomised and directed bench for vivaldi_poly_osc, checked against a frame-level reference model.
module tb_vivaldi_poly_osc;
  localparam int N = 4;
  localparam int M = 32767;

  logic        clk = 1'b0, rst_n = 1'b0, tick = 1'b0, cfg_we = 1'b0, out_ready = 1'b0;
  logic [1:0]  cfg_voice = 2'd0, cfg_addr = 2'd0;
  logic [23:0] cfg_wdata = 24'd0;
  logic signed [15:0] out_data;
  logic        out_valid, busy, overrun;

  int n_vec = 0, n_err = 0, ov_seen = 0, ov_exp = 0;
  int m_phase[N], m_inc[N], m_sel[N], m_gain[N];
  logic [15:0] m_lfsr;

  vivaldi_poly_osc #(.NUM_VOICES(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sample_tick_i(tick), .cfg_we_i(cfg_we),
    .cfg_voice_i(cfg_voice), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy), .overrun_o(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (overrun === 1'b1) ov_seen++;

  task automatic check_eq(string tag, int obs, int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_phase[v] = 0; m_inc[v] = 0; m_sel[v] = 0; m_gain[v] = 0;
    end
    m_lfsr = 16'hACE1;
  endtask

  function automatic int wave_ref(int sel, int ph);
    int k, a, x;
    case (sel)
      0: begin
        k = (ph >> 14) & 255;
        if (((ph >> 22) & 1) == 1) k = 255 - k;
        a = $rtoi(32767.0 * $sin(3.141592653589793 * (real'(k) + 0.5) / 512.0) + 0.5);
        return (ph >= (1 << 23)) ? -a : a;
      end
      1: return (ph < (1 << 23)) ? M : -M;
      2: begin
        x = ph >> 7;
        if (x >= 65536) x = 131071 - x;
        return (x == 65535) ? M : x - M;
      end
      3: return (ph >> 8) - 32768;
`ifdef VIVALDI_NOISE_EN
      4: return int'(signed'(m_lfsr));
`endif
      default: return 0;
    endcase
  endfunction

  // One whole frame: every voice sampled at its current phase, scaled, summed, then saturated
  function automatic int frame_ref();
    int mix, g;
    mix = 0;
    for (int v = 0; v < N; v++) begin
      g = (m_gain[v] > 128) ? 128 : m_gain[v];
      mix += (wave_ref(m_sel[v], m_phase[v]) * g) >>> 7;
      m_phase[v] = (m_phase[v] + m_inc[v]) % (1 << 24);
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hD008) : (m_lfsr >> 1);
    end
    if (mix > 32767) mix = 32767;
    if (mix < -32768) mix = -32768;
    return mix;
  endfunction

  task automatic cfg_write(int v, int a, int d);
    cfg_we = 1'b1; cfg_voice = 2'(v); cfg_addr = 2'(a); cfg_wdata = 24'(d);
    step();
    cfg_we = 1'b0;
    case (a)
      0: m_inc[v] = d & 24'hFFFFFF;
      1: m_sel[v] = d & 7;
      2: m_gain[v] = d & 255;
      default: m_phase[v] = 0;
    endcase
  endtask

  task automatic wait_valid(string tag, int lat0, int exp, output int got);
    int lat;
    lat = lat0;
    while (out_valid !== 1'b1 && lat < N + 8) begin step(); lat++; end
    check_eq({tag, "_lat"}, lat, N + 1);
    got = int'(out_data);
    check_eq({tag, "_data"}, got, exp);
  endtask

  task automatic handshake(string tag);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check_eq({tag, "_vdrop"}, int'(out_valid), 0);
    check_eq({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic run_frame(string tag, int hold, output int got);
    int exp;
    exp = frame_ref();
    tick = 1'b1; step(); tick = 1'b0;
    wait_valid(tag, 1, exp, got);
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq({tag, "_hold"}, int'(out_data), exp);
    end
    handshake(tag);
  endtask

  initial begin
    int got, exp;
    model_reset();
    repeat (3) step();
    check_eq("rst_data", int'(out_data), 0);
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_ovr", int'(overrun), 0);
    rst_n = 1'b1; step();

    // all gains zero
    run_frame("zero", 0, got);
    check_eq("zero_const", got, 0);

    // single square voice, quarter-period step
    cfg_write(0, 1, 1); cfg_write(0, 2, 128); cfg_write(0, 0, 1 << 22);
    for (int i = 0; i < 8; i++) begin
      run_frame("square", 0, got);
      check_eq("square_const", got, ((i % 4) < 2) ? M : -M);
    end

    // four full-scale squares saturate both ways
    for (int v = 0; v < N; v++) begin
      cfg_write(v, 1, 1); cfg_write(v, 2, 128); cfg_write(v, 0, 1 << 23); cfg_write(v, 3, 0);
    end
    run_frame("satpos", 0, got);
    check_eq("satpos_const", got, 32767);
    run_frame("satneg", 0, got);
    check_eq("satneg_const", got, -32768);

    // half-gain sawtooth ramp
    for (int v = 1; v < N; v++) cfg_write(v, 2, 0);
    cfg_write(0, 1, 3); cfg_write(0, 2, 64); cfg_write(0, 0, 1 << 20); cfg_write(0, 3, 0);
    for (int i = 0; i < 17; i++) begin
      run_frame("saw", 0, got);
      check_eq("saw_const", got, -16384 + 2048 * (i % 16));
    end

    // overrun: tick during ACCUM and during OUT with ready held low
    exp = frame_ref();
    tick = 1'b1; step(); step();
    check_eq("ovr_accum", int'(overrun), 1);
    ov_exp++;
    tick = 1'b0;
    wait_valid("ovr", 2, exp, got);
    tick = 1'b1; step(); tick = 1'b0;
    check_eq("ovr_out", int'(overrun), 1);
    ov_exp++;
    step();
    check_eq("ovr_pulse", int'(overrun), 0);
    check_eq("ovr_valid", int'(out_valid), 1);
    check_eq("ovr_stable", int'(out_data), exp);
    handshake("ovr");

    // config writes landing on the voice under evaluation
    for (int v = 2; v < N; v++) begin cfg_write(v, 2, 0); cfg_write(v, 0, 0); end
    cfg_write(0, 1, 1); cfg_write(0, 2, 64); cfg_write(0, 0, 0);       cfg_write(0, 3, 0);
    cfg_write(1, 1, 1); cfg_write(1, 2, 64); cfg_write(1, 0, 1 << 23); cfg_write(1, 3, 0);
    exp = frame_ref();
    tick = 1'b1; step(); tick = 1'b0;
    cfg_we = 1'b1; cfg_voice = 2'd0; cfg_addr = 2'd2; cfg_wdata = 24'd0; step();
    cfg_voice = 2'd1; cfg_addr = 2'd3; step();
    cfg_we = 1'b0;
    m_gain[0] = 0; m_phase[1] = 0;
    wait_valid("midcfg", 3, exp, got);
    check_eq("midcfg_const", got, 32766);
    handshake("midcfg");
    run_frame("aftercfg", 0, got);
    check_eq("aftercfg_const", got, 16383);

    // randomised configuration and handshake delays
    for (int it = 0; it < 40; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 4)); w++)
        cfg_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)), int'($urandom() & 32'hFFFFFF));
      run_frame("rand", int'($urandom_range(0, 2)), got);
    end

    // async reset in the middle of ACCUM
    cfg_write(2, 1, 1); cfg_write(2, 2, 128);
    tick = 1'b1; step(); tick = 1'b0; step();
    check_eq("mid_busy", int'(busy), 1);
    #2 rst_n = 1'b0; #1;
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_valid", int'(out_valid), 0);
    check_eq("arst_data", int'(out_data), 0);
    step(); rst_n = 1'b1; step();
    model_reset();
    run_frame("post_rst", 0, got);
    check_eq("post_rst_const", got, 0);

    check_eq("overrun_count", ov_seen, ov_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
